priority_arbiter: RTL and testbench
===================================

PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 Parameter N, default 8, number of request inputs; legal range 2..32.
REQ-002 Parameter IDX_W, default $clog2(N), width of the encoded grant index; not overridden by instantiators.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  N  request vector; bit i = requester i.
REQ-006 grant_ack  input  1  consumer accepts the presented grant.
REQ-007 grant_valid  output  1  a grant is presented.
REQ-008 grant_idx  output  IDX_W  binary index of the granted requester.
REQ-009 grant_onehot  output  N  one-hot form of grant_idx; all-zero when grant_valid=0.
REQ-010 busy  output  1  high when req is nonzero or grant_valid=1.

Function
REQ-011 Two states: IDLE (no grant presented) and GRANT (grant presented, awaiting ack).
REQ-012 IDLE, req==0: stay IDLE; outputs hold their idle values.
REQ-013 IDLE, req!=0: next edge -> GRANT, grant_valid=1, winner per REQ-017/REQ-018; latency one cycle from req to grant_valid.
REQ-014 GRANT, grant_ack=0: grant_idx and grant_onehot stay frozen, even if req changes or the granted bit drops.
REQ-015 GRANT, grant_ack=1 (transfer): if req!=0 in that cycle, the next edge loads a new winner and stays GRANT (back-to-back, no bubble); otherwise -> IDLE with grant_valid=0.
REQ-016 grant_ack while IDLE is ignored.
REQ-017 Fixed priority: highest set index wins; N-1 is highest, 0 is lowest.
REQ-018 Round-robin (REQ-023): after a transfer of index g, search order is g-1, g-2, ..., 0, N-1, ..., g; wrap from 0 to N-1.
REQ-019 Round-robin pointer updates only on transfer, never on grant presentation alone.
REQ-020 Winner computation uses req as sampled on the loading edge; the granted requester is included again in round-robin order, at lowest priority.
REQ-021 grant_onehot SHALL always equal (1 << grant_idx) when grant_valid=1.

Reset
REQ-022 With rst=1 at an edge: state=IDLE, grant_valid=0, grant_idx=0, grant_onehot=0, round-robin pointer=N-1 (first arbitration equals fixed priority); rst overrides a same-cycle ack or req; busy follows req combinationally once state is reset.

Configuration
REQ-023 Macro PRIORITY_ARBITER_RR_EN: defined -> round-robin per REQ-018/REQ-019 with pointer register; undefined -> fixed priority per REQ-017 only, no pointer register instantiated.

Structure
REQ-024 Shared package pa_pkg: state enum (IDLE, GRANT) and the N range limits as constants.
REQ-025 One sub-module pa_prio_core: combinational highest-set-bit finder over an N-bit vector returning index and found flag; round-robin achieved by rotating req by the pointer before the core and un-rotating the index after it.

Verification (N=8)
REQ-026 Reset: rst=1 two cycles with req=8'hFF, grant_ack=1 -> grant_valid=0, grant_idx=0, grant_onehot=0 throughout.
REQ-027 Fixed priority: req=8'b0010_0101 in IDLE -> next cycle grant_valid=1, grant_idx=5, grant_onehot=8'h20; holds 5 cycles with ack=0 while req changes to 8'h01.
REQ-028 Back-to-back: req=8'h81 steady, ack=1 every cycle -> RR build grants 7,0,7,0...; fixed build grants 7,7,7...; grant_valid never drops.
REQ-029 Wrap-around (RR): pointer after grant to 0, req=8'h11 -> next grant is 4, then 0.
REQ-030 Release to idle: GRANT idx 3, ack=1 with req=0 -> next cycle grant_valid=0, grant_onehot=0, busy=0.
REQ-031 Reset mid-operation: GRANT idx 6, rst=1 with ack=1 -> next cycle IDLE, outputs zero; RR pointer back to 7, next req=8'h41 grants 6.

Source files
------------

// File: rtl/pa_pkg.sv
// Shared types and limits for the priority arbiter.
package pa_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } pa_state_e;

    localparam int PA_N_MIN = 2;
    localparam int PA_N_MAX = 32;

endpackage

// File: rtl/pa_prio_core.sv
// Combinational highest-set-bit finder: idx is the top set bit of vec, found = |vec.
module pa_prio_core
    import pa_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Ascending scan: the last set bit written is the highest one.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter.sv
// Grant-and-hold arbiter: fixed priority (N-1 highest), or round-robin when
// PRIORITY_ARBITER_RR_EN is defined.
module priority_arbiter
    import pa_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             grant_ack,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N-1:0]     grant_onehot,
    output logic             busy
);

    if (N < PA_N_MIN || N > PA_N_MAX) begin : g_bad_n
        $error("priority_arbiter: N out of range");
    end

    pa_state_e        state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic             transfer;
    logic [N-1:0]     core_vec;
    logic [IDX_W-1:0] core_idx;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;

    assign transfer = (state_q == GRANT) && grant_ack;

`ifdef PRIORITY_ARBITER_RR_EN
    localparam logic [IDX_W-1:0] PTR_TOP = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   N_EXT   = (IDX_W + 1)'(N);

    // Pointer holds the highest-priority index; N-1 reproduces fixed priority.
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W:0]   rot_amt;
    logic [IDX_W:0]   unrot_raw;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (transfer) begin
            rr_ptr_d = (grant_idx_q == '0) ? PTR_TOP : grant_idx_q - 1'b1;
        end
    end

    // Arbitrate with the post-transfer pointer so back-to-back grants rotate.
    assign rot_amt   = {1'b0, rr_ptr_d} + (IDX_W + 1)'(1);
    assign core_vec  = N'({req, req} >> rot_amt);
    assign unrot_raw = (IDX_W + 1)'(core_idx) + rot_amt;
    assign win_idx   = (unrot_raw >= N_EXT) ? IDX_W'(unrot_raw - N_EXT)
                                            : IDX_W'(unrot_raw);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= PTR_TOP;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign core_vec = req;
    assign win_idx  = core_idx;
`endif

    pa_prio_core #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_core (
        .vec   (core_vec),
        .idx   (core_idx),
        .found (win_found)
    );

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = GRANT;
                    grant_idx_d = win_idx;
                end
            end
            GRANT: begin
                if (grant_ack) begin
                    if (win_found) begin
                        grant_idx_d = win_idx;
                    end else begin
                        state_d     = IDLE;
                        grant_idx_d = '0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                grant_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign grant_valid  = (state_q == GRANT);
    assign grant_idx    = grant_idx_q;
    assign grant_onehot = grant_valid ? (N'(1) << grant_idx_q) : '0;
    assign busy         = (|req) | grant_valid;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed table-driven bench for priority_arbiter (N=8), both build variants.
module tb_priority_arbiter;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic             grant_ack;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [N-1:0]     grant_onehot;
    logic             busy;

    int n_chk;
    int n_fail;

    priority_arbiter #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant_ack    (grant_ack),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       ack;
        logic       exp_valid;
        logic       chk_idx;
        logic [2:0] exp_idx;
        logic [7:0] exp_onehot;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] rq, input logic a);
        rst       = r;
        req       = rq;
        grant_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic ci,
                              input logic [2:0] idx, input logic [7:0] oh, input logic b);
        chk({name, ".valid"}, 32'(grant_valid), 32'(v));
        if (ci) chk({name, ".idx"}, 32'(grant_idx), 32'(idx));
        chk({name, ".onehot"}, 32'(grant_onehot), 32'(oh));
        chk({name, ".busy"}, 32'(busy), 32'(b));
    endtask

    // Expected index for a grant whose value differs between builds.
    function automatic logic [2:0] sel(input logic [2:0] rr_val, input logic [2:0] fx_val);
`ifdef PRIORITY_ARBITER_RR_EN
        return rr_val;
`else
        return fx_val;
`endif
    endfunction

    initial begin
        logic [2:0] e;
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req       = '0;
        grant_ack = 1'b0;

        //          rst   req    ack   vld   ci    idx   onehot busy
        vecs[0]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1};
        vecs[1]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1};
        vecs[2]  = '{1'b0, 8'h25, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20, 1'b1};
        vecs[3]  = '{1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20, 1'b1};
        vecs[4]  = '{1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20, 1'b1};
        vecs[5]  = '{1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20, 1'b1};
        vecs[6]  = '{1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20, 1'b1};
        vecs[7]  = '{1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20, 1'b1};
        vecs[8]  = '{1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1};
        vecs[10] = '{1'b0, 8'h08, 1'b1, 1'b1, 1'b1, 3'd3, 8'h08, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
        vecs[13] = '{1'b0, 8'h18, 1'b0, 1'b1, 1'b1, 3'd4, 8'h10, 1'b1};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].ack);
            expect_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].chk_idx,
                       vecs[i].exp_idx, vecs[i].exp_onehot, vecs[i].exp_busy);
        end

        // Back-to-back transfers with two requesters held high.
        step(1'b1, 8'h81, 1'b0);
        expect_out("b2b_rst", 1'b0, 1'b1, 3'd0, 8'h00, 1'b1);
        step(1'b0, 8'h81, 1'b0);
        expect_out("b2b_first", 1'b1, 1'b1, 3'd7, 8'h80, 1'b1);
        for (int k = 0; k < 6; k++) begin
            e = (k % 2 == 0) ? sel(3'd0, 3'd7) : 3'd7;
            step(1'b0, 8'h81, 1'b1);
            expect_out($sformatf("b2b%0d", k), 1'b1, 1'b1, e, 8'(1) << e, 1'b1);
        end

        // Wrap-around from index 0 back to the top of the order.
        step(1'b0, 8'h01, 1'b1);
        expect_out("wrap_g0", 1'b1, 1'b1, 3'd0, 8'h01, 1'b1);
        step(1'b0, 8'h11, 1'b1);
        expect_out("wrap_g4", 1'b1, 1'b1, 3'd4, 8'h10, 1'b1);
        e = sel(3'd0, 3'd4);
        step(1'b0, 8'h11, 1'b1);
        expect_out("wrap_next", 1'b1, 1'b1, e, 8'(1) << e, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        expect_out("release", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

        // Reset in the middle of a grant, with ack asserted, restores the pointer.
        step(1'b0, 8'h40, 1'b0);
        expect_out("mid_g6", 1'b1, 1'b1, 3'd6, 8'h40, 1'b1);
        step(1'b0, 8'h40, 1'b1);
        expect_out("mid_g6b", 1'b1, 1'b1, 3'd6, 8'h40, 1'b1);
        step(1'b1, 8'h40, 1'b1);
        expect_out("mid_rst", 1'b0, 1'b1, 3'd0, 8'h00, 1'b1);
        step(1'b0, 8'h41, 1'b0);
        expect_out("post_rst", 1'b1, 1'b1, 3'd6, 8'h40, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
